shift_unit_iter: RTL and testbench
==================================

// Module: shift_unit_iter
// PURPOSE
//  Parametrised multi-bit shifter/rotator for the ALU datapath.
//  Shifts operand A by the amount held in B[AMT_W-1:0], working STEP bit positions per cycle.
//  Valid/ready handshake on the input and output sides, so the ALU issue logic can stall it.
//  Result carries the last bit shifted out as its MSB (carry), giving IN_WIDTH+1 output bits.
// PARAMETERS
//  IN_WIDTH   16  operand width; power of 2, >= 4
//  STEP       1   bit positions shifted per BUSY cycle; power of 2, 1..IN_WIDTH/2
//  AMT_W      localparam = $clog2(IN_WIDTH); width of the shift amount
// PORTS
//  CLK        in   1           clock, rising edge
//  RST        in   1           asynchronous reset, active-low
//  IN_VALID   in   1           operands and ALU_FUN valid
//  IN_READY   out  1           unit can accept (state IDLE)
//  A          in   IN_WIDTH    operand to shift, signed
//  B          in   IN_WIDTH    shift amount in B[AMT_W-1:0]; upper bits ignored
//  ALU_FUN    in   3           0 SRL, 1 SLL, 2 SRA, 3 ROR, 4 ROL, 5-7 reserved
//  OUT_READY  in   1           consumer accepts result
//  SHIFT_OUT  out  IN_WIDTH+1  {carry, result}
//  Shift_Flag out  1           result valid (state DONE)
//  Busy       out  1           high in BUSY
// BEHAVIOUR
//  - Reset (RST low, async): state IDLE; SHIFT_OUT=0, Shift_Flag=0, Busy=0, IN_READY=1; internal counters 0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: IN_READY=1. Transfer on IN_VALID&&IN_READY: latch A, ALU_FUN and amt=B[AMT_W-1:0]; clear carry.
//  - Transfer goes to DONE next cycle (result=A, carry=0) when amt==0 or ALU_FUN is reserved; otherwise goes to BUSY.
//  - BUSY: each cycle shifts by s=min(STEP,remaining); remaining-=s; carry=last bit moved out.
//  - BUSY exits to DONE on the cycle remaining reaches 0.
//  - Latency (accept edge to Shift_Flag high) = ceil(amt/STEP)+1 cycles; amt==0 gives 1 cycle.
//  - DONE: Shift_Flag=1; SHIFT_OUT stable until OUT_READY sampled high, then IDLE.
//  - DONE: no same-cycle accept; IN_READY=0 in BUSY and DONE.
//  - Operations:
//    - SRL/SLL fill with 0; SRA fills with A[IN_WIDTH-1].
//    - SRL/SRA carry = last bit out of LSB; SLL carry = last bit out of MSB.
//    - ROR carry = bit that arrived in MSB; ROL carry = bit that arrived in LSB.
//  - Max amt = IN_WIDTH-1; no modulo beyond the AMT_W bits.
//  - SHIFT_OUT holds the last result in IDLE (not cleared). Shift_Flag is cleared on leaving DONE.
//  - Reset mid-operation aborts immediately; no partial result is ever flagged valid.
//  - Inputs A/B/ALU_FUN are don't-care outside the accept cycle.
// CONFIGURATION
//  Macro SHIFT_ZERO_FLAG_EN:
//   - Defined: extra output Zero_Flag (1 bit) = (result bits [IN_WIDTH-1:0]==0). Registered with SHIFT_OUT; valid with Shift_Flag; reset 0.
//   - Undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  Package shift_pkg:
//   - shift_op_e (SRL=0,SLL=1,SRA=2,ROR=3,ROL=4)
//   - shift_state_e (IDLE,BUSY,DONE)
//   - function is_reserved_op
//  Sub-module shift_step (combinational): {data,op,s} -> {next_data,carry}.
//   - Handles 1..STEP positions; instantiated once.
//   - FSM, counter and handshake live in shift_unit_iter.
// TESTING
//  1 SLL A=16'h8001 amt=1, STEP=1 -> Shift_Flag after 2 cycles, SHIFT_OUT=17'h1_0002
//  2 SRA A=16'h8000 amt=4 -> SHIFT_OUT=17'h0_F800; latency 5 (STEP=1), 3 (STEP=2)
//  3 ROR A=16'h0001 amt=1 -> 17'h1_8000; ROL A=16'h8000 amt=1 -> 17'h1_0001
//  4 amt=0 or ALU_FUN=7, A=16'h1234 -> 17'h0_1234 after 1 cycle, Busy never high
//  5 OUT_READY low 5 cycles in DONE -> SHIFT_OUT/Shift_Flag stable; IN_READY=0 and IN_VALID ignored
//  6 RST low during BUSY -> all outputs 0 asynchronously; next op after release correct
//  (SHIFT_ZERO_FLAG_EN) SRL A=16'h0001 amt=1 -> Zero_Flag=1, carry=1

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: operation codes, FSM states and the
// reserved-opcode test used at accept time.
package shift_pkg;

    typedef enum logic [2:0] {
        SRL = 3'd0,
        SLL = 3'd1,
        SRA = 3'd2,
        ROR = 3'd3,
        ROL = 3'd4
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } shift_state_e;

    function automatic logic is_reserved_op(input logic [2:0] fun);
        return fun > 3'd4;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift/rotate of up to STEP positions. Reports the last bit
// moved out (or, for rotates, the last bit moved in at the far end).
module shift_step
    import shift_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int STEP     = 1,
    parameter int AMT_W    = $clog2(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0] data,
    input  shift_op_e           op,
    input  logic [AMT_W-1:0]    s,
    output logic [IN_WIDTH-1:0] next_data,
    output logic                carry
);

    // Unrolled as STEP single-position stages; stages beyond s pass through.
    always_comb begin
        next_data = data;
        carry     = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(s)) begin
                case (op)
                    SRL: begin
                        carry     = next_data[0];
                        next_data = {1'b0, next_data[IN_WIDTH-1:1]};
                    end
                    SLL: begin
                        carry     = next_data[IN_WIDTH-1];
                        next_data = {next_data[IN_WIDTH-2:0], 1'b0};
                    end
                    SRA: begin
                        carry     = next_data[0];
                        next_data = {next_data[IN_WIDTH-1], next_data[IN_WIDTH-1:1]};
                    end
                    ROR: begin
                        carry     = next_data[0];
                        next_data = {next_data[0], next_data[IN_WIDTH-1:1]};
                    end
                    ROL: begin
                        carry     = next_data[IN_WIDTH-1];
                        next_data = {next_data[IN_WIDTH-2:0], next_data[IN_WIDTH-1]};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Iterative shifter/rotator with valid/ready on both sides; STEP bits per cycle.
// Optional Zero_Flag output enabled by defining SHIFT_ZERO_FLAG_EN.
//
//  state | meaning
//  IDLE  | ready for operands; SHIFT_OUT holds previous result
//  BUSY  | shifting, remaining amount counts down to zero
//  DONE  | result valid, waiting for OUT_READY
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int STEP     = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [IN_WIDTH-1:0] A,
    input  logic [IN_WIDTH-1:0] B,
    input  logic [2:0]          ALU_FUN,
    input  logic                OUT_READY,
    output logic [IN_WIDTH:0]   SHIFT_OUT,
    output logic                Shift_Flag,
    output logic                Busy
`ifdef SHIFT_ZERO_FLAG_EN
    ,output logic               Zero_Flag
`endif
);

    localparam int AMT_W = $clog2(IN_WIDTH);
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    shift_state_e        state, state_nxt;
    logic [IN_WIDTH-1:0] data_r;
    shift_op_e           op_r;
    logic [AMT_W-1:0]    rem_r;
    logic [IN_WIDTH:0]   out_r;

    logic [AMT_W-1:0]    amt_in;
    logic [AMT_W-1:0]    s;
    logic [IN_WIDTH-1:0] step_data;
    logic                step_carry;
    logic                ld_accept;
    logic                ld_step;
    logic                ld_result;
    logic [IN_WIDTH:0]   result_nxt;
    logic                unused_b_hi;

    assign amt_in      = B[AMT_W-1:0];
    assign unused_b_hi = ^B[IN_WIDTH-1:AMT_W];
    assign s           = (rem_r < STEP_AMT) ? rem_r : STEP_AMT;
    assign SHIFT_OUT   = out_r;

    shift_step #(
        .IN_WIDTH (IN_WIDTH),
        .STEP     (STEP),
        .AMT_W    (AMT_W)
    ) u_step (
        .data      (data_r),
        .op        (op_r),
        .s         (s),
        .next_data (step_data),
        .carry     (step_carry)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        IN_READY   = 1'b0;
        Busy       = 1'b0;
        Shift_Flag = 1'b0;
        ld_accept  = 1'b0;
        ld_step    = 1'b0;
        ld_result  = 1'b0;
        result_nxt = {1'b0, data_r};
        case (state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    ld_accept = 1'b1;
                    // Nothing to shift: pass A straight through with a clear carry.
                    if (amt_in == '0 || is_reserved_op(ALU_FUN)) begin
                        state_nxt  = DONE;
                        ld_result  = 1'b1;
                        result_nxt = {1'b0, A};
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                Busy    = 1'b1;
                ld_step = 1'b1;
                if (rem_r == s) begin
                    state_nxt  = DONE;
                    ld_result  = 1'b1;
                    result_nxt = {step_carry, step_data};
                end
            end
            DONE: begin
                Shift_Flag = 1'b1;
                if (OUT_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_r <= '0;
            op_r   <= SRL;
            rem_r  <= '0;
        end else if (ld_accept) begin
            data_r <= A;
            op_r   <= shift_op_e'(ALU_FUN);
            rem_r  <= amt_in;
        end else if (ld_step) begin
            data_r <= step_data;
            rem_r  <= rem_r - s;
        end
    end

    // Separate result register so SHIFT_OUT never shows intermediate shifts.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)           out_r <= '0;
        else if (ld_result) out_r <= result_nxt;
    end

`ifdef SHIFT_ZERO_FLAG_EN
    logic zero_r;
    assign Zero_Flag = zero_r;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)           zero_r <= 1'b0;
        else if (ld_result) zero_r <= (result_nxt[IN_WIDTH-1:0] == '0);
    end
`endif

endmodule

// File: tb/tb_shift_unit_iter.sv
// Scoreboard bench for shift_unit_iter: directed vectors push expected results,
// a negedge monitor pops and compares each new result and its latency.
module tb_shift_unit_iter;

    localparam int W    = 16;
    localparam int STEP = 1;
    localparam int AW   = $clog2(W);

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   ALU_FUN = '0;
    logic         OUT_READY = 1'b1;
    logic [W:0]   SHIFT_OUT;
    logic         Shift_Flag;
    logic         Busy;
`ifdef SHIFT_ZERO_FLAG_EN
    logic         Zero_Flag;
`endif

    shift_unit_iter #(.IN_WIDTH(W), .STEP(STEP)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .OUT_READY  (OUT_READY),
        .SHIFT_OUT  (SHIFT_OUT),
        .Shift_Flag (Shift_Flag),
        .Busy       (Busy)
`ifdef SHIFT_ZERO_FLAG_EN
        ,.Zero_Flag (Zero_Flag)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W:0] exp;
        int         lat;
        int         acc_cyc;
    } item_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   fun;
        logic [W:0]   exp;
    } vec_t;

    item_t sb[$];
    item_t mon_it;
    vec_t  vecs[14];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    logic  flag_prev = 1'b0;
    logic  busy_seen = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] fun, input logic [W:0] exp);
        item_t it;
        int    n;
        int    amt;
        @(negedge CLK);
        A        = a;
        B        = b;
        ALU_FUN  = fun;
        IN_VALID = 1'b1;
        n = 0;
        while (!IN_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: IN_READY low for %0d cycles", n);
            IN_VALID = 1'b0;
        end else begin
            @(posedge CLK);
            #1;
            IN_VALID   = 1'b0;
            amt        = int'(b[AW-1:0]);
            it.exp     = exp;
            it.lat     = (amt == 0 || fun > 3'd4) ? 1 : (amt + STEP - 1) / STEP + 1;
            it.acc_cyc = cyc;
            sb.push_back(it);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (Busy) busy_seen = 1'b1;
        if (RST && Shift_Flag && !flag_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h want none", SHIFT_OUT);
            end else begin
                mon_it = sb.pop_front();
                check("shift_out", SHIFT_OUT, mon_it.exp);
                check_int("latency", cyc - mon_it.acc_cyc + 1, mon_it.lat);
`ifdef SHIFT_ZERO_FLAG_EN
                check("zero_flag", {{W{1'b0}}, Zero_Flag},
                      {{W{1'b0}}, (mon_it.exp[W-1:0] == '0)});
`endif
            end
        end
        flag_prev = Shift_Flag;
    end

    initial begin
        vecs = '{
            '{16'h8001, 16'd1,    3'd1, 17'h1_0002},  // SLL 1
            '{16'h8000, 16'd4,    3'd2, 17'h0_F800},  // SRA 4
            '{16'h0001, 16'd1,    3'd3, 17'h1_8000},  // ROR 1
            '{16'h8000, 16'd1,    3'd4, 17'h1_0001},  // ROL 1
            '{16'h0001, 16'd1,    3'd0, 17'h1_0000},  // SRL 1 -> zero result
            '{16'hF0F0, 16'd15,   3'd0, 17'h1_0001},  // SRL max
            '{16'h00FF, 16'd8,    3'd1, 17'h0_FF00},  // SLL 8
            '{16'h7FFF, 16'd15,   3'd2, 17'h1_0000},  // SRA max, positive
            '{16'h1234, 16'd4,    3'd4, 17'h1_2341},  // ROL 4
            '{16'h1234, 16'd4,    3'd3, 17'h0_4123},  // ROR 4
            '{16'h8000, 16'hFFF3, 3'd2, 17'h0_F000},  // upper B bits ignored
            '{16'h8001, 16'd15,   3'd1, 17'h0_8000},  // SLL max
            '{16'h1234, 16'd0,    3'd0, 17'h0_1234},  // amt 0
            '{16'hABCD, 16'd3,    3'd5, 17'h0_ABCD}   // reserved op
        };

        #2;
        check("rst_shift_out", SHIFT_OUT, '0);
        check("rst_flag", {16'd0, Shift_Flag}, 17'd0);
        check("rst_busy", {16'd0, Busy}, 17'd0);
        check("rst_in_ready", {16'd0, IN_READY}, 17'd1);
        @(negedge CLK);
        RST = 1'b1;

        busy_seen = 1'b0;
        issue(vecs[0].a, vecs[0].b, vecs[0].fun, vecs[0].exp);
        drain();
        check("busy_seen_shift", {16'd0, busy_seen}, 17'd1);

        for (int i = 1; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].exp);
            drain();
        end

        busy_seen = 1'b0;
        issue(16'h1234, 16'd0, 3'd0, 17'h0_1234);
        drain();
        issue(16'h1234, 16'd5, 3'd7, 17'h0_1234);
        drain();
        issue(vecs[12].a, vecs[12].b, vecs[12].fun, vecs[12].exp);
        drain();
        issue(vecs[13].a, vecs[13].b, vecs[13].fun, vecs[13].exp);
        drain();
        check("busy_seen_passthru", {16'd0, busy_seen}, 17'd0);

        // Consumer stall in DONE with a competing request on the input side.
        OUT_READY = 1'b0;
        issue(16'h00FF, 16'd8, 3'd1, 17'h0_FF00);
        drain();
        A        = 16'hFFFF;
        B        = 16'd1;
        ALU_FUN  = 3'd0;
        IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall_out", SHIFT_OUT, 17'h0_FF00);
            check("stall_flag", {16'd0, Shift_Flag}, 17'd1);
            check("stall_in_ready", {16'd0, IN_READY}, 17'd0);
            check("stall_busy", {16'd0, Busy}, 17'd0);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("release_flag", {16'd0, Shift_Flag}, 17'd0);
        check("release_in_ready", {16'd0, IN_READY}, 17'd1);
        check("idle_hold_out", SHIFT_OUT, 17'h0_FF00);

        // Asynchronous reset in the middle of a long shift.
        issue(16'hF0F0, 16'd15, 3'd0, 17'h1_0001);
        repeat (3) @(negedge CLK);
        check("pre_rst_busy", {16'd0, Busy}, 17'd1);
        #2;
        RST = 1'b0;
        #1;
        check("abort_shift_out", SHIFT_OUT, '0);
        check("abort_flag", {16'd0, Shift_Flag}, 17'd0);
        check("abort_busy", {16'd0, Busy}, 17'd0);
        check("abort_in_ready", {16'd0, IN_READY}, 17'd1);
        sb.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        issue(16'h0001, 16'd1, 3'd3, 17'h1_8000);
        drain();
        issue(16'h8001, 16'd1, 3'd1, 17'h1_0002);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
